morse_tx_sequencer: RTL and testbench
=====================================

# morse_tx_sequencer

Controller that sequences Morse keying for a queued message. It buffers up to MAX_LETTERS 5-bit letter codes (0 = A … 25 = Z) from the front-panel input path. On start it fetches each letter's pattern and drives the key output one pattern bit per Morse unit, inserting fixed letter and word gaps. It sits between the switch/key input logic and the LED/buzzer key output, and replaces free-running shift-out with handshaked sequencing.

## Interface
- TICK_CYCLES, 25000000 — clock cycles per Morse unit; must be ≥ 2.
- MAX_LETTERS, 10 — letter FIFO depth; must be ≥ 2.
- LETTER_GAP, 3 — key-off units after each letter.
- WORD_GAP, 7 — key-off units emitted for an invalid code (26–31), which acts as a word space.

- clock  in  1  system clock, rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- letter  in  5  letter code to enqueue.
- wr_valid  in  1  enqueue request.
- wr_ready  out  1  FIFO not full; a write happens when wr_valid && wr_ready.
- start  in  1  begin transmission; sampled only in IDLE.
- abort  in  1  stop immediately and flush the FIFO.
- key  out  1  Morse key (1 = tone/LED on).
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when the FIFO drains normally.
- count  out  $clog2(MAX_LETTERS+1)  letters currently queued.

## Operation
**Pattern encoding.** Patterns are 14 bits, MSB first: dot = 1, dash = 111, intra-letter space = 0.
- A 10111, B 111010101, C 11101011101, D 1110101, E 1, F 101011101, G 111011101, H 1010101, I 101, J 1011101110111, K 111010111, L 101110101, M 1110111, N 11101, O 11101110111, P 10111011101, Q 1110111010111, R 1011101, S 10101, T 111, U 1010111, V 101010111, W 101110111, X 11101010111, Y 1110101110111, Z 11101110101.
- Each pattern is left-aligned with zero fill.
- Only bits up to and including the last 1 are sent. The trailing zero fill is never sent as key-off units.

**States.**
- IDLE: key=0, busy=0.
  - start && count>0 → LOAD.
  - start && count==0 → ignored; no done pulse.
- LOAD (exactly 1 cycle, key=0):
  - Pop the FIFO head.
  - Valid code: load the pattern into the shift register → SEND.
  - Invalid code: load gap_cnt = WORD_GAP−1 → GAP.
  - Restart the unit counter at TICK_CYCLES−1.
- SEND:
  - key = shift register MSB.
  - At the end of each unit: if the remaining bits after the MSB are nonzero, shift left by 1 and stay in SEND. Otherwise load gap_cnt = LETTER_GAP−1 → GAP.
- GAP: key=0. At the end of each unit:
  - gap_cnt > 0: decrement.
  - gap_cnt == 0 and count > 0: → LOAD.
  - gap_cnt == 0 and count == 0: → DONE.
- DONE (1 cycle): done=1, key=0 → IDLE.

**Boundary conditions.**
- abort, from any state: next state IDLE, key=0, FIFO emptied, done not asserted. abort has priority over start and over a write in the same cycle; that write is dropped.
- Write and pop in the same cycle: both take effect, and count is unchanged.
- Write while full: wr_ready=0, so no write occurs.
- Writes are accepted in every state, so the message may be extended while it is transmitting.
- FIFO pointers wrap modulo MAX_LETTERS.
- Reset mid-transmission behaves like abort.

## Timing
- Reset values: key=0, busy=0, done=0, count=0, wr_ready=1, state IDLE, pointers 0.
- All outputs are registered or decoded from registered state. No combinational path from any input to key, done or busy.
- Start latency: start sampled at edge N → LOAD in cycle N+1 → key shows the first pattern bit from cycle N+2.
- Unit length: every SEND or GAP unit lasts exactly TICK_CYCLES cycles.
- Letter boundaries:
  - A following valid letter begins LETTER_GAP·TICK_CYCLES + 1 cycles after its predecessor's last key-on unit ends; the +1 is the LOAD cycle.
  - An invalid code contributes 1 + WORD_GAP·TICK_CYCLES key-off cycles.
- Completion: done pulses in the cycle after the final gap unit ends. busy falls in the cycle after done.
- Wr_ready and count update in the cycle after a write or pop.

## Test plan
Parameters for all scenarios: TICK_CYCLES=4, MAX_LETTERS=4, LETTER_GAP=3, WORD_GAP=7.

1. **Reset and single letter.** Reset, then enqueue E (4), then pulse start.
   - key=1 for exactly 4 cycles starting 2 cycles after start.
   - Then key=0 for 12 cycles, then done=1 for 1 cycle.
   - busy low the following cycle; count=0.
2. **Two-letter message.** Enqueue A (0) then T (19), then start.
   - key sequence per 4-cycle unit is 1,0,1,1,1.
   - Then 12 key-off cycles plus 1 LOAD cycle.
   - Then 3 on units, then 3 gap units, then done.
3. **Word space.** Enqueue E, 31, E, then start.
   - Between the two E on-units: 12 + 1 + 28 + 1 = 42 key-off cycles.
   - Exactly one done pulse.
4. **Full FIFO.** Write 5 letters back-to-back.
   - wr_ready drops after the 4th write; the 5th is not stored; count=4.
   - A write in the same cycle as the LOAD pop leaves count unchanged.
5. **Abort.** Abort mid-SEND of J.
   - Next cycle: key=0, busy=0, count=0.
   - No done pulse.
   - A later start with an empty FIFO does nothing.
6. **Synchronous reset mid-GAP.** Deassert reset_n for 1 cycle while in GAP.
   - All outputs return to their reset values on the next edge.
   - A new message then transmits normally.

Source files
------------

// File: rtl/morse_tx_sequencer.sv
// Morse keying sequencer: queues 5-bit letter codes in a small FIFO and plays each
// letter's dot/dash pattern one bit per Morse unit, with letter and word gaps.
module morse_tx_sequencer #(
    parameter int TICK_CYCLES = 25000000,
    parameter int MAX_LETTERS = 10,
    parameter int LETTER_GAP  = 3,
    parameter int WORD_GAP    = 7
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [4:0]                         letter,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    input  logic                               start,
    input  logic                               abort,
    output logic                               key,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(MAX_LETTERS+1)-1:0]   count
);

    localparam int CW      = $clog2(MAX_LETTERS + 1);
    localparam int PW      = $clog2(MAX_LETTERS);
    localparam int TW      = $clog2(TICK_CYCLES);
    localparam int GAP_MAX = (WORD_GAP > LETTER_GAP) ? WORD_GAP : LETTER_GAP;
    localparam int GW      = $clog2(GAP_MAX + 1);

    localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_LETTERS - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(MAX_LETTERS);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [GW-1:0] LGAP_LAST  = GW'(LETTER_GAP - 1);
    localparam logic [GW-1:0] WGAP_LAST  = GW'(WORD_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [4:0]    fifo_mem [MAX_LETTERS];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    head;
    logic          head_valid;
    logic          push;
    logic          pop;

    logic [TW-1:0] tick_cnt;
    logic [GW-1:0] gap_cnt;
    logic [13:0]   shreg;
    logic          unit_end;
    logic          more_bits;

    // Left-aligned patterns, MSB first; a zero return marks a word-space code.
    function automatic logic [13:0] pattern_of(input logic [4:0] code);
        logic [13:0] p;
        case (code)
            5'd0:    p = 14'b10111_000000000;
            5'd1:    p = 14'b111010101_00000;
            5'd2:    p = 14'b11101011101_000;
            5'd3:    p = 14'b1110101_0000000;
            5'd4:    p = 14'b1_0000000000000;
            5'd5:    p = 14'b101011101_00000;
            5'd6:    p = 14'b111011101_00000;
            5'd7:    p = 14'b1010101_0000000;
            5'd8:    p = 14'b101_00000000000;
            5'd9:    p = 14'b1011101110111_0;
            5'd10:   p = 14'b111010111_00000;
            5'd11:   p = 14'b101110101_00000;
            5'd12:   p = 14'b1110111_0000000;
            5'd13:   p = 14'b11101_000000000;
            5'd14:   p = 14'b11101110111_000;
            5'd15:   p = 14'b10111011101_000;
            5'd16:   p = 14'b1110111010111_0;
            5'd17:   p = 14'b1011101_0000000;
            5'd18:   p = 14'b10101_000000000;
            5'd19:   p = 14'b111_00000000000;
            5'd20:   p = 14'b1010111_0000000;
            5'd21:   p = 14'b101010111_00000;
            5'd22:   p = 14'b101110111_00000;
            5'd23:   p = 14'b11101010111_000;
            5'd24:   p = 14'b1110101110111_0;
            5'd25:   p = 14'b11101110101_000;
            default: p = 14'b0;
        endcase
        return p;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign head       = fifo_mem[rd_ptr];
    assign head_valid = (head <= 5'd25);
    assign wr_ready   = (count != COUNT_FULL);
    assign push       = wr_valid && wr_ready && !abort;
    assign pop        = (state == LOAD) && !abort;
    assign unit_end   = (tick_cnt == '0);
    assign more_bits  = |shreg[12:0];

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= letter;
        end
    end

    // Abort shares the reset path so a flush also returns the pointers to zero.
    always_ff @(posedge clock) begin
        if (!reset_n || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            gap_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    tick_cnt <= TICK_LAST;
                    if (head_valid) begin
                        shreg <= pattern_of(head);
                    end else begin
                        gap_cnt <= WGAP_LAST;
                    end
                end
                SEND: begin
                    tick_cnt <= unit_end ? TICK_LAST : tick_cnt - 1'b1;
                    if (unit_end) begin
                        if (more_bits) begin
                            shreg <= shreg << 1;
                        end else begin
                            gap_cnt <= LGAP_LAST;
                        end
                    end
                end
                GAP: begin
                    tick_cnt <= unit_end ? TICK_LAST : tick_cnt - 1'b1;
                    if (unit_end && (gap_cnt != '0)) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (start && (count != '0)) next_state = LOAD;
                LOAD: next_state = head_valid ? SEND : GAP;
                SEND: if (unit_end && !more_bits) next_state = GAP;
                GAP: begin
                    if (unit_end && (gap_cnt == '0)) begin
                        next_state = (count != '0) ? LOAD : DONE;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        key  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        if (state == SEND) key = shreg[13];
        if (state != IDLE) busy = 1'b1;
        if (state == DONE) done = 1'b1;
    end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Directed bench for morse_tx_sequencer with small parameters (4-cycle units, 4-deep FIFO);
// key timing is checked cycle by cycle against hand-derived unit sequences.
module tb_morse_tx_sequencer;

    localparam int TICK = 4;
    localparam int MAXL = 4;
    localparam int LGAP = 3;
    localparam int WGAP = 7;
    localparam int CW   = $clog2(MAXL + 1);

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b0;
    logic [4:0]    letter   = 5'd0;
    logic          wr_valid = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          wr_ready;
    logic          key;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    int total = 0;
    int bad = 0;
    int done_pulses = 0;
    int pulses_before = 0;

    morse_tx_sequencer #(
        .TICK_CYCLES (TICK),
        .MAX_LETTERS (MAXL),
        .LETTER_GAP  (LGAP),
        .WORD_GAP    (WGAP)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .letter   (letter),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .start    (start),
        .abort    (abort),
        .key      (key),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done) done_pulses++;
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] code);
        wr_valid = 1'b1;
        letter   = code;
        nextCycle();
        wr_valid = 1'b0;
    endtask

    task automatic startTx(input string tag);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        checkOutput({tag, "_load_key"}, key, 0);
        checkOutput({tag, "_load_busy"}, busy, 1);
    endtask

    task automatic expectKey(input string tag, input logic val, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            nextCycle();
            checkOutput(tag, key, val);
        end
    endtask

    task automatic expectDone(input string tag);
        nextCycle();
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_done_key"}, key, 0);
        nextCycle();
        checkOutput({tag, "_after_done"}, done, 0);
        checkOutput({tag, "_after_busy"}, busy, 0);
        checkOutput({tag, "_after_count"}, count, 0);
    endtask

    initial begin
        $display("[TB] morse_tx_sequencer directed test");
        repeat (3) nextCycle();
        checkOutput("rst_key", key, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_wr_ready", wr_ready, 1);
        reset_n = 1'b1;
        nextCycle();

        // Single E: one on-unit, three gap units, then the done pulse.
        pulses_before = done_pulses;
        applyStimulus(5'd4);
        checkOutput("s1_count", count, 1);
        startTx("s1");
        expectKey("s1_on", 1'b1, 4);
        expectKey("s1_gap", 1'b0, 12);
        expectDone("s1");
        checkOutput("s1_pulses", done_pulses - pulses_before, 1);

        // A then T: units 1,0,1,1,1 / gap + LOAD / 1,1,1 / gap.
        pulses_before = done_pulses;
        applyStimulus(5'd0);
        applyStimulus(5'd19);
        checkOutput("s2_count", count, 2);
        startTx("s2");
        expectKey("s2_a_dot", 1'b1, 4);
        expectKey("s2_a_sp", 1'b0, 4);
        expectKey("s2_a_dash", 1'b1, 12);
        expectKey("s2_gap_load", 1'b0, 13);
        expectKey("s2_t_dash", 1'b1, 12);
        expectKey("s2_gap", 1'b0, 12);
        expectDone("s2");
        checkOutput("s2_pulses", done_pulses - pulses_before, 1);

        // E, word space, E: 42 key-off cycles between the two on-units.
        pulses_before = done_pulses;
        applyStimulus(5'd4);
        applyStimulus(5'd31);
        applyStimulus(5'd4);
        startTx("s3");
        expectKey("s3_e1", 1'b1, 4);
        expectKey("s3_space", 1'b0, 42);
        expectKey("s3_e2", 1'b1, 4);
        expectKey("s3_gap", 1'b0, 12);
        expectDone("s3");
        checkOutput("s3_pulses", done_pulses - pulses_before, 1);

        // Fill the FIFO, then write during a LOAD pop.
        pulses_before = done_pulses;
        wr_valid = 1'b1;
        letter   = 5'd4;
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            checkOutput("s4_fill_count", count, k);
            checkOutput("s4_fill_ready", wr_ready, (k < 4) ? 1 : 0);
        end
        letter = 5'd8;
        nextCycle();
        wr_valid = 1'b0;
        checkOutput("s4_full_count", count, 4);
        checkOutput("s4_full_ready", wr_ready, 0);
        startTx("s4");
        checkOutput("s4_load_count", count, 4);
        expectKey("s4_e1", 1'b1, 4);
        checkOutput("s4_pop_count", count, 3);
        expectKey("s4_e1_gap", 1'b0, 12);
        nextCycle();
        checkOutput("s4_load2_key", key, 0);
        checkOutput("s4_load2_count", count, 3);
        wr_valid = 1'b1;
        letter   = 5'd19;
        nextCycle();
        wr_valid = 1'b0;
        checkOutput("s4_pushpop_count", count, 3);
        checkOutput("s4_e2_first", key, 1);
        expectKey("s4_e2", 1'b1, 3);
        expectKey("s4_e2_gap", 1'b0, 13);
        expectKey("s4_e3", 1'b1, 4);
        expectKey("s4_e3_gap", 1'b0, 13);
        expectKey("s4_e4", 1'b1, 4);
        expectKey("s4_e4_gap", 1'b0, 13);
        expectKey("s4_t", 1'b1, 12);
        expectKey("s4_t_gap", 1'b0, 12);
        expectDone("s4");
        checkOutput("s4_pulses", done_pulses - pulses_before, 1);

        // Abort in the middle of J's first dash, with a write in the same cycle.
        pulses_before = done_pulses;
        applyStimulus(5'd9);
        applyStimulus(5'd4);
        startTx("s5");
        expectKey("s5_j_dot", 1'b1, 4);
        expectKey("s5_j_sp", 1'b0, 4);
        expectKey("s5_j_dash", 1'b1, 2);
        abort    = 1'b1;
        wr_valid = 1'b1;
        letter   = 5'd4;
        nextCycle();
        abort    = 1'b0;
        wr_valid = 1'b0;
        checkOutput("s5_abort_key", key, 0);
        checkOutput("s5_abort_busy", busy, 0);
        checkOutput("s5_abort_count", count, 0);
        checkOutput("s5_abort_ready", wr_ready, 1);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        checkOutput("s5_empty_start_busy", busy, 0);
        nextCycle();
        checkOutput("s5_empty_start_busy2", busy, 0);
        checkOutput("s5_pulses", done_pulses - pulses_before, 0);

        // Synchronous reset while in the letter gap, then a fresh message.
        pulses_before = done_pulses;
        applyStimulus(5'd4);
        applyStimulus(5'd4);
        startTx("s6");
        expectKey("s6_e1", 1'b1, 4);
        expectKey("s6_gap_part", 1'b0, 5);
        reset_n = 1'b0;
        nextCycle();
        reset_n = 1'b1;
        checkOutput("s6_rst_key", key, 0);
        checkOutput("s6_rst_busy", busy, 0);
        checkOutput("s6_rst_done", done, 0);
        checkOutput("s6_rst_count", count, 0);
        checkOutput("s6_rst_ready", wr_ready, 1);
        applyStimulus(5'd19);
        checkOutput("s6_new_count", count, 1);
        startTx("s6b");
        expectKey("s6_t", 1'b1, 12);
        expectKey("s6_t_gap", 1'b0, 12);
        expectDone("s6");
        checkOutput("s6_pulses", done_pulses - pulses_before, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
